// File: rtl/mandel_pkg.sv
// Shared constants, state encoding and colour definitions for the Mandelbrot
// escape-time engine.
package mandel_pkg;

  // Fixed-point format of c and z (Q4.28 at defaults).
  localparam int WIDTH    = 32;
  localparam int FRAC     = 28;

  // Iteration counter width and cap.
  localparam int ITER_W   = 9;
  localparam int MAX_ITER = 256;

  // |z|^2 threshold (4.0) in the Q.2FRAC format of the squared magnitude.
  localparam logic [2*WIDTH:0] ESCAPE_LIMIT = (2*WIDTH+1)'(4) << (2*FRAC);

  // RGB333 colour word stored by the display buffer.
  localparam int                  COLOUR_W      = 9;
  localparam logic [COLOUR_W-1:0] COLOUR_INSIDE = 9'h000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mandel_iter_core_palette.sv
// Escape-count to RGB333 colour map. Points inside the set are black; fast
// escapes are bright. Kept apart from the FSM so the palette can be swapped.
module mandel_palette
  import mandel_pkg::*;
#(
  parameter int ITER_W   = mandel_pkg::ITER_W,
  parameter int MAX_ITER = mandel_pkg::MAX_ITER
) (
  input  logic [ITER_W-1:0]   n_i,
  output logic [COLOUR_W-1:0] colour_o
);

  logic [COLOUR_W-1:0] n_low;

  // Colour from the low bits of the count; the cap itself maps to black.
  always_comb begin
    n_low = COLOUR_W'(n_i);
    if (n_i == ITER_W'(MAX_ITER)) begin
      colour_o = COLOUR_INSIDE;
    end else begin
      colour_o = {COLOUR_W{1'b1}} - n_low;
    end
  end

endmodule

// File: rtl/mandel_iter_core.sv
// Per-pixel Mandelbrot escape-time engine: accepts c, iterates z <- z^2 + c
// from z = 0 at one iteration per cycle, and returns the escape count plus an
// RGB333 colour through valid/ready handshakes on both sides.
module mandel_iter_core
  import mandel_pkg::*;
#(
  parameter int WIDTH    = mandel_pkg::WIDTH,
  parameter int FRAC     = mandel_pkg::FRAC,
  parameter int ITER_W   = mandel_pkg::ITER_W,
  parameter int MAX_ITER = mandel_pkg::MAX_ITER
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    c_re,
  input  logic [WIDTH-1:0]    c_im,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ITER_W-1:0]   iter_count,
  output logic [COLOUR_W-1:0] colour_data,
  output logic                busy
);

  localparam logic [2*WIDTH:0] ESC_LIMIT = (2*WIDTH+1)'(4) << (2*FRAC);

  state_t                     state_q, state_d;
  logic signed [WIDTH-1:0]    c_re_q, c_re_d;
  logic signed [WIDTH-1:0]    c_im_q, c_im_d;
  logic signed [WIDTH-1:0]    zr_q, zr_d;
  logic signed [WIDTH-1:0]    zi_q, zi_d;
  logic [ITER_W-1:0]          n_q, n_d;
  logic [ITER_W-1:0]          iter_count_q, iter_count_d;
  logic [COLOUR_W-1:0]        colour_q, colour_d;

  // Full-precision datapath (Q.2FRAC products).
  logic signed [2*WIDTH-1:0]  zr_ext, zi_ext;
  logic signed [2*WIDTH-1:0]  zr_sq, zi_sq, zr_zi;
  logic signed [2*WIDTH-1:0]  re_full, im_full;
  logic [2*WIDTH:0]           mag2;
  logic                       escaped;
  logic                       at_cap;
  logic signed [WIDTH-1:0]    zr_next, zi_next;
  logic [COLOUR_W-1:0]        pal_colour;
  logic                       unused_frac_bits;

  // Squares and cross product of z, escape test and the candidate next z.
  always_comb begin
    zr_ext  = {{WIDTH{zr_q[WIDTH-1]}}, zr_q};
    zi_ext  = {{WIDTH{zi_q[WIDTH-1]}}, zi_q};
    zr_sq   = zr_ext * zr_ext;
    zi_sq   = zi_ext * zi_ext;
    zr_zi   = zr_ext * zi_ext;
    // Both squares are non-negative, so an unsigned sum one bit wider is exact.
    mag2    = {1'b0, zr_sq} + {1'b0, zi_sq};
    escaped = (mag2 > ESC_LIMIT);
    at_cap  = (n_q == ITER_W'(MAX_ITER));
    re_full = zr_sq - zi_sq;
    im_full = zr_zi <<< 1;
    // Plain slice = truncation toward negative infinity, no rounding.
    zr_next = re_full[FRAC+WIDTH-1:FRAC] + c_re_q;
    zi_next = im_full[FRAC+WIDTH-1:FRAC] + c_im_q;
  end

  // Bits below the fixed point and above the Q4 range are intentionally dropped.
  assign unused_frac_bits = ^{re_full[2*WIDTH-1:FRAC+WIDTH], re_full[FRAC-1:0],
                              im_full[2*WIDTH-1:FRAC+WIDTH], im_full[FRAC-1:0]};

  mandel_palette #(
    .ITER_W   (ITER_W),
    .MAX_ITER (MAX_ITER)
  ) u_palette (
    .n_i      (n_q),
    .colour_o (pal_colour)
  );

  // Next-state and datapath update for the IDLE -> ITER -> DONE sequence.
  always_comb begin
    // NOTE: every _d gets a hold default first so no path infers a latch.
    state_d      = state_q;
    c_re_d       = c_re_q;
    c_im_d       = c_im_q;
    zr_d         = zr_q;
    zi_d         = zi_q;
    n_d          = n_q;
    iter_count_d = iter_count_q;
    colour_d     = colour_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          c_re_d  = c_re;
          c_im_d  = c_im;
          zr_d    = '0;
          zi_d    = '0;
          n_d     = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        if (escaped || at_cap) begin
          iter_count_d = n_q;
          colour_d     = pal_colour;
          state_d      = DONE;
        end else begin
          zr_d = zr_next;
          zi_d = zi_next;
          n_d  = n_q + ITER_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q      <= IDLE;
      c_re_q       <= '0;
      c_im_q       <= '0;
      zr_q         <= '0;
      zi_q         <= '0;
      n_q          <= '0;
      iter_count_q <= '0;
      colour_q     <= '0;
    end else begin
      state_q      <= state_d;
      c_re_q       <= c_re_d;
      c_im_q       <= c_im_d;
      zr_q         <= zr_d;
      zi_q         <= zi_d;
      n_q          <= n_d;
      iter_count_q <= iter_count_d;
      colour_q     <= colour_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign iter_count  = iter_count_q;
  assign colour_data = colour_q;

endmodule

// File: tb/tb_mandel_iter_core.sv
// Self-checking bench for mandel_iter_core: spec vectors from a table,
// hand-written backpressure and reset-abort sequences, and random points
// compared against a plain-arithmetic escape-time model.
module tb_mandel_iter_core;

  localparam int WIDTH    = 32;
  localparam int FRAC     = 28;
  localparam int ITER_W   = 9;
  localparam int MAX_ITER = 256;
  localparam int TIMEOUT  = 400;

  logic              clk_in = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  c_re;
  logic [WIDTH-1:0]  c_im;
  logic              out_valid;
  logic              out_ready;
  logic [ITER_W-1:0] iter_count;
  logic [8:0]        colour_data;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  mandel_iter_core #(
    .WIDTH    (WIDTH),
    .FRAC     (FRAC),
    .ITER_W   (ITER_W),
    .MAX_ITER (MAX_ITER)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .c_re        (c_re),
    .c_im        (c_im),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .iter_count  (iter_count),
    .colour_data (colour_data),
    .busy        (busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] cre;
    logic [31:0] cim;
    int          exp_n;
    logic [8:0]  exp_colour;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Escape-time reference: plain 64-bit arithmetic on Q4.28 values.
  function automatic int ref_escape(input int cre, input int cim);
    longint zr = 0;
    longint zi = 0;
    longint lim = 64'sd4 <<< (2*FRAC);
    longint tr, ti;
    int n = 0;
    while (1) begin
      if ((zr*zr + zi*zi) > lim || n == MAX_ITER) return n;
      tr = ((zr*zr - zi*zi) >>> FRAC) + longint'(cre);
      ti = ((2*zr*zi) >>> FRAC) + longint'(cim);
      zr = longint'(int'(tr));
      zi = longint'(int'(ti));
      n++;
    end
    return n;
  endfunction

  function automatic logic [8:0] ref_colour(input int n);
    if (n == MAX_ITER) return 9'h000;
    return 9'(511 - (n % 512));
  endfunction

  // Caller is at a negedge with the core idle; returns at the negedge after
  // the result has been consumed (core back in IDLE).
  task automatic run_point(input logic [31:0] cre, input logic [31:0] cim,
                           input int exp_n, input logic [8:0] exp_col,
                           input int hold, input string tag);
    int cyc;
    c_re     = cre;
    c_im     = cim;
    in_valid = 1'b1;
    check({tag, "_in_ready_idle"}, in_ready, 1);
    @(negedge clk_in);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < TIMEOUT) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) check({tag, "_busy_iter"}, {busy, in_ready}, 2'b10);
      @(negedge clk_in);
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_n + 2);
    check({tag, "_iter_count"}, iter_count, exp_n);
    check({tag, "_colour"}, colour_data, exp_col);
    check({tag, "_done_flags"}, {out_valid, busy, in_ready}, 3'b110);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      c_re     = 32'h0;
      c_im     = 32'h0;
      @(negedge clk_in);
      check({tag, "_hold_flags"}, {out_valid, in_ready}, 2'b10);
      check({tag, "_hold_result"}, {iter_count, colour_data}, {9'(exp_n), exp_col});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk_in);
    out_ready = 1'b0;
    check({tag, "_back_idle"}, {in_ready, out_valid, busy}, 3'b100);
  endtask

  vec_t vecs[6];

  initial begin
    int n_exp;
    int seen;
    logic [31:0] rre, rim;

    vecs[0] = '{32'h1800_0000, 32'h0000_0000, 2,   9'h1FD}; // 1.5
    vecs[1] = '{32'h0000_0000, 32'h0000_0000, 256, 9'h000}; // origin
    vecs[2] = '{32'hE000_0000, 32'h0000_0000, 256, 9'h000}; // -2, |z|=2 exactly
    vecs[3] = '{32'h0000_0000, 32'h1800_0000, 2,   9'h1FD}; // 1.5i
    vecs[4] = '{32'h0000_0000, 32'hE000_0000, 2,   9'h1FD}; // -2i
    vecs[5] = '{32'h0400_0000, 32'h0000_0000, 256, 9'h000}; // 0.25 cusp

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    c_re      = '0;
    c_im      = '0;
    repeat (3) @(negedge clk_in);
    check("reset_state", {in_ready, out_valid, busy, iter_count, colour_data},
          {1'b1, 1'b0, 1'b0, 9'h0, 9'h0});
    reset = 1'b0;
    @(negedge clk_in);

    foreach (vecs[i])
      run_point(vecs[i].cre, vecs[i].cim, vecs[i].exp_n, vecs[i].exp_colour,
                0, $sformatf("vec%0d", i));

    // Backpressure: result held for 20 cycles while a new point is offered.
    run_point(32'h1800_0000, 32'h0, 2, 9'h1FD, 20, "bp");
    // The very next point is accepted straight away and computed correctly.
    run_point(32'h0000_0000, 32'h1800_0000, 2, 9'h1FD, 0, "after_bp");

    // Reset during ITER aborts the point and never produces a result.
    c_re     = 32'h0;
    c_im     = 32'h0;
    in_valid = 1'b1;
    check("rst_mid_accept", in_ready, 1);
    @(negedge clk_in);
    in_valid = 1'b0;
    repeat (9) @(negedge clk_in);
    check("rst_mid_busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    check("rst_mid_state", {in_ready, out_valid, busy, iter_count, colour_data},
          {1'b1, 1'b0, 1'b0, 9'h0, 9'h0});
    seen = 0;
    repeat (300) begin
      @(negedge clk_in);
      if (out_valid) seen++;
    end
    check("rst_mid_no_stale", seen, 0);

    // Random points in [-2, 2) against the reference model.
    for (int k = 0; k < 40; k++) begin
      rre   = 32'($signed(32'($urandom_range(0, 32'h3FFF_FFFF))) - 32'sh2000_0000);
      rim   = 32'($signed(32'($urandom_range(0, 32'h3FFF_FFFF))) - 32'sh2000_0000);
      n_exp = ref_escape(int'(rre), int'(rim));
      run_point(rre, rim, n_exp, ref_colour(n_exp), int'($urandom_range(0, 3)),
                $sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mandel_iter_core.md
Name: mandel_iter_core

Overview:
- Per-pixel Mandelbrot escape-time engine, directly upstream of the display buffer and downstream of the address mapper.
- Accepts one complex point c = (c_re, c_im) in signed fixed point and iterates z <- z^2 + c from z = 0.
- Produces the iteration count and a 9-bit RGB333 colour word, the format the display buffer stores.
- Uses a valid/ready handshake on both sides, so the top level can stall it without clock gating.

Parameters:
- WIDTH, 32: bit width of each coordinate and of z components, two's complement.
- FRAC, 28: fractional bits (Q4.28 at defaults).
- ITER_W, 9: width of the iteration counter and iter_count output.
- MAX_ITER, 256: iteration cap. Must be < 2^ITER_W and <= 511.

Ports:
- clk_in  input  1  clock
- reset  input  1  synchronous, active-high
- in_valid  input  1  c_re/c_im valid
- in_ready  output  1  core can accept a point
- c_re  input  WIDTH  real part of c, signed QX.FRAC
- c_im  input  WIDTH  imaginary part of c, signed QX.FRAC
- out_valid  output  1  result valid; held until consumed
- out_ready  input  1  downstream accepts result
- iter_count  output  ITER_W  escape count n (MAX_ITER = did not escape)
- colour_data  output  9  RGB333 colour, {R[2:0],G[2:0],B[2:0]}
- busy  output  1  high in ITER or DONE

Behaviour:
- Reset (clock: clk_in; reset: reset, synchronous, active-high)
  - State becomes IDLE.
  - in_ready=1, out_valid=0, iter_count=0, colour_data=0, busy=0.
  - z and the counter are cleared.
  - Reset asserted mid-ITER or in DONE aborts the point; the result is discarded.
- FSM states: IDLE, ITER, DONE.
  - IDLE: in_ready=1. On in_valid & in_ready, latch c, set z=0, n=0, go to ITER. Nothing else in IDLE.
  - ITER: in_ready=0, one iteration per cycle.
    - Compute full-precision products zr*zr, zi*zi, zr*zi (2*WIDTH-bit signed, Q.2FRAC).
    - Define mag2 = zr^2 + zi^2 at full precision.
    - If mag2 > (4 << 2*FRAC) (strictly greater) or n == MAX_ITER: latch n to iter_count, latch the colour, go to DONE. z is not updated that cycle.
    - Otherwise:
      - zr <= (zr^2 - zi^2)[FRAC+WIDTH-1:FRAC] + c_re
      - zi <= (2*zr*zi)[FRAC+WIDTH-1:FRAC] + c_im
      - n <= n + 1
      - Truncation toward negative infinity (arithmetic slice); no rounding.
  - DONE: out_valid=1. iter_count and colour_data are stable until out_ready=1.
    - On out_valid & out_ready, go to IDLE.
    - in_ready stays 0 in DONE, giving one bubble cycle before the next accept.
- Latency: accept at cycle T, result count n -> out_valid first high at T+n+2 (n+1 ITER cycles).
- Input range: c_re and c_im must be in [-2, 2).
  - Escape is checked before each update, so |z| <= 2 holds whenever z is updated.
  - New components stay below 6 and fit Q4.28 without saturation.
  - Out-of-range inputs are undefined; the bench does not drive them.
- Colour:
  - n == MAX_ITER (inside the set) -> 9'h000.
  - Otherwise -> 9'h1FF - n[8:0]. Fast escape is bright.
  - Computed combinationally from n at termination and registered with iter_count.
- Simultaneous events:
  - in_valid while not in IDLE is ignored; upstream holds the point.
  - out_ready while out_valid=0 has no effect.
- busy = (state != IDLE).

Decomposition:
- Shared package mandel_pkg holds:
  - Fixed-point constants: WIDTH, FRAC, ESCAPE_LIMIT = 4 << 2*FRAC.
  - State enum {IDLE, ITER, DONE}.
  - COLOUR_W = 9 and COLOUR_INSIDE = 9'h000.
- One sub-module, mandel_palette: combinational n -> 9-bit colour mapping. Kept separate so palettes can be swapped without touching the FSM.
- Multipliers are inferred inline in the core.

Test Plan:
- Reset mid-ITER: accept c=(0,0), assert reset at T+10 -> next cycle in_ready=1, out_valid=0, iter_count=0, colour_data=0, busy=0. No stale result ever appears.
- c_re=0x18000000 (1.5), c_im=0:
  - Trajectory z: 0 -> 1.5 -> 3.75, then escape (mag2 = 14.06).
  - iter_count=2, colour_data=9'h1FD, out_valid at T+4.
- c_re=0x00000000, c_im=0x00000000:
  - Never escapes; iter_count=256, colour_data=9'h000.
  - out_valid at T+258, busy high T+1..T+258.
- Boundary c_re=0xE0000000 (-2), c_im=0:
  - z cycles -2, 2, 2, ... with mag2 exactly 4 (not escape, strict >).
  - iter_count=256, colour_data=9'h000.
- c_re=0, c_im=0x18000000 (1.5i): z -> (0,1.5) -> (-2.25,1.5), escape -> iter_count=2, colour_data=9'h1FD.
- Backpressure: c=(1.5,0) with out_ready=0 for 20 cycles after out_valid.
  - out_valid, iter_count=2 and colour 9'h1FD are held; in_ready=0 and in_valid is ignored throughout.
  - The cycle after out_ready=1, the core is in IDLE and accepts the next point.
